temp_table_writer: RTL and testbench
====================================

Name: temp_table_writer

Overview:
- Sequential generator that computes both temperature conversion tables and writes them, entry by entry, into the conversion RAMs through a write port with a ready handshake.
- Writer-side counterpart of the conversion lookup path; used at power-up, or on demand, to fill the tables with arithmetic instead of preloaded memory files.
- Celsius→Fahrenheit table: address C = 0..100, data = F.
- Fahrenheit→Celsius table: address F−32 = 0..180, data = C.
- Arithmetic uses a shift-add multiply and a restoring divider; no DSP or division operator.

Parameters:
- SIZE, 8, width of address and data words.
- C_MAX, 100, last Celsius entry; the Fahrenheit table spans 0..(C_MAX*9/5).
- DIV_W, 11, numerator/divider working width; must hold (max × 9 + 4).

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-low reset
- start  in  1  single-cycle request to build both tables
- wr_ready  in  1  RAM accepts the write presented this cycle
- wr_en  out  1  write request; held with addr/data stable until wr_ready
- wr_sel  out  1  0 = C→F table, 1 = F→C table
- wr_addr  out  SIZE  table address
- wr_data  out  SIZE  converted value
- busy  out  1  high from accepted start until the last write is accepted
- done  out  1  sticky completion flag

Behaviour:
- Reset (rst=0 at clk edge):
  - state=IDLE; wr_en, wr_sel, wr_addr, wr_data, busy, done all 0.
  - Applies immediately mid-build; the write in flight is abandoned and the table is left partial.
- IDLE:
  - start=1 → LOAD, with idx=0, wr_sel=0, busy=1, done=0.
  - start is ignored in every other state.
- LOAD (1 cycle): form the numerator by shift-add, then → DIV.
  - wr_sel=0: num = idx·9 + 2 = (idx<<3) + idx + 2.
  - wr_sel=1: num = idx·5 + 4 = (idx<<2) + idx + 4.
- DIV (DIV_W cycles): restoring shift-subtract divide.
  - Divisor: 5 when wr_sel=0, 9 when wr_sel=1.
  - Quotient is exact truncation of num/div; the +2 / +4 terms give round-half-up.
- WRITE:
  - wr_en=1; wr_addr=idx; wr_data = quotient + 32 (sel 0) or quotient (sel 1), truncated to SIZE.
  - Holds wr_en, wr_addr and wr_data stable until wr_ready=1 at a clk edge; that edge completes the write.
  - wr_ready low stalls indefinitely with no timeout.
- NEXT (entered on the accepting edge; wr_en=0 the following cycle):
  - sel 0, idx<C_MAX: idx+1 → LOAD.
  - sel 0, idx=C_MAX: wr_sel=1, idx=0 → LOAD.
  - sel 1, idx<C_MAX·9/5: idx+1 → LOAD.
  - sel 1, idx=C_MAX·9/5 (180): → DONE.
- DONE (1 cycle): busy=0, done=1 → IDLE.
  - done stays 1 until reset or the next accepted start.
- Timing:
  - Per entry with wr_ready tied high: 1 (LOAD) + DIV_W + 1 (WRITE) + 1 (NEXT) = DIV_W+3 cycles.
  - Total with defaults: 282 entries × 14 cycles = 3948 cycles from start to done.
  - wr_en is never high for two consecutive accepted writes; minimum gap is DIV_W+2 cycles.
- Boundaries:
  - Every value falls inside 0..255; no saturation logic.
  - C=100 → 212; F=212 (addr 180) → 100.
  - wr_ready high while wr_en=0 is ignored.

Optional Feature:
- Macro: TEMP_TABLE_CHECKSUM_EN.
- Defined:
  - Adds output checksum[15:0], cleared on accepted start and on reset.
  - Adds the zero-extended wr_data of each accepted write, modulo 2^16.
  - Valid when done=1; holds its value until the next start.
- Not defined: port absent; no added logic.

Test Plan:
- Reset, pulse start, wr_ready=1 → writes in order (0,0,32), (0,37,99), (0,100,212), (1,0,0), (1,66,37), (1,180,100) as (sel,addr,data); done rises 3948 cycles after start; exactly 282 wr_en pulses.
- Full build against a reference model of round((x·9)/5)+32 and round((x·5)/9) → every entry matches; no address repeats or gaps.
- Hold wr_ready=0 for 20 cycles during entry (0,50) → wr_en, addr and data (50, 122) stable throughout; the write completes on the first wr_ready=1 edge; total time grows by exactly 20.
- Pulse start again at entry (1,10) while busy → ignored; the sequence continues unchanged; a single done.
- Drive rst=0 at entry (1,90) → next edge: wr_en=0, busy=0, done=0; a new start restarts from (0,0).
- With TEMP_TABLE_CHECKSUM_EN → at done, checksum equals the model sum of all 282 data values; it clears to 0 on the next start.

Source files
------------

// File: rtl/temp_table_writer.sv
// temp_table_writer: builds the Celsius->Fahrenheit and Fahrenheit->Celsius
// conversion tables one entry at a time and writes them to the table RAMs.
// Each entry is computed with a shift-add multiply and a restoring divider.
// Optional build macro TEMP_TABLE_CHECKSUM_EN adds a 16-bit running sum of
// all accepted write data on the checksum output.
module temp_table_writer #(
  parameter int unsigned SIZE  = 8,
  parameter int unsigned C_MAX = 100,
  parameter int unsigned DIV_W = 11
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic            wr_ready,
  output logic            wr_en,
  output logic            wr_sel,
  output logic [SIZE-1:0] wr_addr,
  output logic [SIZE-1:0] wr_data,
  output logic            busy,
  output logic            done
`ifdef TEMP_TABLE_CHECKSUM_EN
  ,
  output logic [15:0]     checksum
`endif
);

  localparam int unsigned F_MAX = (C_MAX * 9) / 5;
  localparam int unsigned CNT_W = $clog2(DIV_W + 1);
  localparam int unsigned REM_W = DIV_W - 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_DIV,
    S_WRITE,
    S_NEXT,
    S_DONE
  } state_t;

  state_t             state;
  logic [SIZE-1:0]    idx;
  logic [CNT_W-1:0]   cnt;
  logic [REM_W-1:0]   rem;
  logic [DIV_W-1:0]   quo;

  logic [DIV_W-1:0]   num_c;
  logic [DIV_W-1:0]   divisor_c;
  logic [DIV_W-1:0]   trial_c;
  logic [REM_W-1:0]   rem_nxt_c;
  logic [DIV_W-1:0]   quo_nxt_c;
  logic [SIZE-1:0]    data_c;

  // Numerator for the current entry: idx*9+2 (C->F) or idx*5+4 (F->C)
  always_comb begin
    num_c = '0;
    if (!wr_sel) begin
      num_c = (DIV_W'(idx) << 3) + DIV_W'(idx) + DIV_W'(2);
    end else begin
      num_c = (DIV_W'(idx) << 2) + DIV_W'(idx) + DIV_W'(4);
    end
  end

  // One restoring shift-subtract step; quotient bits shift in from the right
  always_comb begin
    divisor_c = wr_sel ? DIV_W'(9) : DIV_W'(5);
    trial_c   = {rem, quo[DIV_W-1]};
    rem_nxt_c = REM_W'(trial_c);
    quo_nxt_c = {quo[DIV_W-2:0], 1'b0};
    if (trial_c >= divisor_c) begin
      rem_nxt_c = REM_W'(trial_c - divisor_c);
      quo_nxt_c = {quo[DIV_W-2:0], 1'b1};
    end
  end

  // Table value from the final quotient; C->F entries carry the +32 offset
  always_comb begin
    data_c = wr_sel ? SIZE'(quo_nxt_c) : SIZE'(quo_nxt_c + DIV_W'(32));
  end

  // Sequencer: load numerator, divide, write with handshake, advance index
  always_ff @(posedge clk) begin
    if (!rst) begin
      state    <= S_IDLE;
      idx      <= '0;
      cnt      <= '0;
      rem      <= '0;
      quo      <= '0;
      wr_en    <= 1'b0;
      wr_sel   <= 1'b0;
      wr_addr  <= '0;
      wr_data  <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
`ifdef TEMP_TABLE_CHECKSUM_EN
      checksum <= '0;
`endif
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            state    <= S_LOAD;
            idx      <= '0;
            wr_sel   <= 1'b0;
            busy     <= 1'b1;
            done     <= 1'b0;
`ifdef TEMP_TABLE_CHECKSUM_EN
            checksum <= '0;
`endif
          end
        end
        S_LOAD: begin
          quo   <= num_c;
          rem   <= '0;
          cnt   <= '0;
          state <= S_DIV;
        end
        S_DIV: begin
          quo <= quo_nxt_c;
          rem <= rem_nxt_c;
          cnt <= cnt + CNT_W'(1);
          if (cnt == CNT_W'(DIV_W - 1)) begin
            state   <= S_WRITE;
            wr_en   <= 1'b1;
            wr_addr <= idx;
            wr_data <= data_c;
          end
        end
        S_WRITE: begin
          if (wr_ready) begin
            wr_en    <= 1'b0;
            state    <= S_NEXT;
`ifdef TEMP_TABLE_CHECKSUM_EN
            checksum <= checksum + 16'(wr_data);
`endif
          end
        end
        S_NEXT: begin
          if (!wr_sel) begin
            state <= S_LOAD;
            if (idx == SIZE'(C_MAX)) begin
              wr_sel <= 1'b1;
              idx    <= '0;
            end else begin
              idx <= idx + SIZE'(1);
            end
          end else if (idx == SIZE'(F_MAX)) begin
            state <= S_DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end else begin
            idx   <= idx + SIZE'(1);
            state <= S_LOAD;
          end
        end
        S_DONE: begin
          state <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_temp_table_writer.sv
// Bench for temp_table_writer: directed builds with a rounding reference
// model, write stall, ignored restart, mid-build reset and optional checksum.
module tb_temp_table_writer;

  logic       clk;
  logic       rst;
  logic       start;
  logic       wr_ready;
  logic       wr_en;
  logic       wr_sel;
  logic [7:0] wr_addr;
  logic [7:0] wr_data;
  logic       busy;
  logic       done;
`ifdef TEMP_TABLE_CHECKSUM_EN
  logic [15:0] checksum;
`endif

  int tests;
  int fails;

  temp_table_writer dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .wr_ready (wr_ready),
    .wr_en    (wr_en),
    .wr_sel   (wr_sel),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data),
    .busy     (busy),
    .done     (done)
`ifdef TEMP_TABLE_CHECKSUM_EN
    ,
    .checksum (checksum)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    if (obs !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Round-half-up of c*9/5, plus 32
  function automatic int c2f(input int c);
    int q;
    int r;
    q = (c * 9) / 5;
    r = (c * 9) % 5;
    if (2 * r >= 5) q++;
    return q + 32;
  endfunction

  // Round-half-up of a*5/9
  function automatic int f2c(input int a);
    int q;
    int r;
    q = (a * 5) / 9;
    r = (a * 5) % 9;
    if (2 * r >= 9) q++;
    return q;
  endfunction

  // Hand-computed spot entries (sel, addr, data)
  int spot_sel  [6] = '{0, 0,  0,   1, 1,  1};
  int spot_addr [6] = '{0, 37, 100, 0, 66, 180};
  int spot_data [6] = '{32, 99, 212, 0, 37, 100};

  task automatic pulse_start();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  // Runs one full build; optional stall at entry (0,50) and extra start at (1,10)
  task automatic run_build(input int stall_len, input bit dup_start,
                           output int cycles, output int sum);
    int  exp_sel;
    int  exp_addr;
    int  exp_data;
    int  writes;
    int  stalled;
    bit  fin;
    exp_sel  = 0;
    exp_addr = 0;
    writes   = 0;
    stalled  = 0;
    cycles   = 0;
    sum      = 0;
    fin      = 1'b0;
    wr_ready = 1'b1;
    pulse_start();
    check("busy_after_start", busy, 1);
    check("done_cleared", done, 0);
`ifdef TEMP_TABLE_CHECKSUM_EN
    check("checksum_cleared", checksum, 0);
`endif
    while (!fin && cycles < 8000) begin
      if (done) begin
        fin = 1'b1;
      end else begin
        if (wr_en) begin
          if (exp_sel == 0 && exp_addr == 50 && stalled < stall_len) begin
            wr_ready = 1'b0;
            check("stall_hold", {wr_sel, wr_addr, wr_data}, {1'b0, 8'd50, 8'd122});
            stalled++;
          end else begin
            wr_ready = 1'b1;
            exp_data = (exp_sel == 1) ? f2c(exp_addr) : c2f(exp_addr);
            check("entry", {wr_sel, wr_addr, wr_data},
                  {exp_sel[0], 8'(exp_addr), 8'(exp_data)});
            for (int i = 0; i < 6; i++) begin
              if (spot_sel[i] == exp_sel && spot_addr[i] == exp_addr)
                check("spot", {wr_sel, wr_addr, wr_data},
                      {spot_sel[i][0], 8'(spot_addr[i]), 8'(spot_data[i])});
            end
            sum += exp_data;
            writes++;
            if (dup_start && exp_sel == 1 && exp_addr == 10) start = 1'b1;
            if (exp_sel == 0 && exp_addr == 100) begin
              exp_sel  = 1;
              exp_addr = 0;
            end else begin
              exp_addr++;
            end
          end
        end
        @(posedge clk); #1;
        cycles++;
        start = 1'b0;
      end
    end
    check("build_finished", fin, 1);
    check("write_count", writes, 282);
    check("busy_at_done", busy, 0);
  endtask

  int cyc;
  int sum;
  int n;
  bit seen;

  initial begin
    tests    = 0;
    fails    = 0;
    rst      = 1'b0;
    start    = 1'b0;
    wr_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_wr_en", wr_en, 0);
    check("rst_outputs", {wr_sel, wr_addr, wr_data}, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
`ifdef TEMP_TABLE_CHECKSUM_EN
    check("rst_checksum", checksum, 0);
`endif
    rst = 1'b1;
    @(posedge clk); #1;

    // Plain build, ready always high
    run_build(0, 1'b0, cyc, sum);
    check("build_cycles", cyc, 3948);
`ifdef TEMP_TABLE_CHECKSUM_EN
    check("checksum_sum", checksum, 32'(sum[15:0]));
`endif
    repeat (2) @(posedge clk);
    #1;

    // Build with a 20-cycle stall at entry (0,50)
    run_build(20, 1'b0, cyc, sum);
    check("stall_cycles", cyc, 3968);
    repeat (2) @(posedge clk);
    #1;

    // Build with a start pulse during entry (1,10)
    run_build(0, 1'b1, cyc, sum);
    check("dup_cycles", cyc, 3948);
    n = 0;
    for (int i = 0; i < 40; i++) begin
      if (wr_en || busy) n++;
      @(posedge clk); #1;
    end
    check("idle_after_done", n, 0);
    check("done_sticky", done, 1);

    // Reset asserted during entry (1,90), then restart
    wr_ready = 1'b1;
    pulse_start();
    seen = 1'b0;
    for (int i = 0; i < 5000 && !seen; i++) begin
      if (wr_en && wr_sel && wr_addr == 8'd90) seen = 1'b1;
      else begin
        @(posedge clk); #1;
      end
    end
    check("reach_1_90", seen, 1);
    rst = 1'b0;
    @(posedge clk); #1;
    check("midrst_wr_en", wr_en, 0);
    check("midrst_busy", busy, 0);
    check("midrst_done", done, 0);
    rst = 1'b1;
    @(posedge clk); #1;
    pulse_start();
    seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      if (wr_en) seen = 1'b1;
      else begin
        @(posedge clk); #1;
      end
    end
    check("restart_seen", seen, 1);
    check("restart_entry", {wr_sel, wr_addr, wr_data}, {1'b0, 8'd0, 8'd32});

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
